// File: rtl/game_state_ctrl.sv
// game_state_ctrl: round sequencer (IDLE/PLAY/DYING/OVER) for the bird game.
// Gates object motion, issues the round reset pulse and keeps the BCD score
// and the high score. Every output comes straight from a register.
module game_state_ctrl #(
   parameter int DIE_FRAMES = 60,
   parameter int PASS_X     = 265
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       flap,
   input  logic       collision,
   input  logic [9:0] pipe_x,
   output logic [1:0] state,
   output logic       motion_en,
   output logic       round_reset,
   output logic [7:0] score_bcd,
   output logic [7:0] high_bcd,
   output logic       new_high
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DYING = 2'd2,
      OVER  = 2'd3
   } st_t;

   localparam logic [9:0] PX       = PASS_X[9:0];
   localparam logic [7:0] DIE_LAST = 8'(DIE_FRAMES - 1);

   st_t        st;
   logic       flap_q;
   logic [7:0] die_cnt;
   logic [9:0] pipe_x_last;
   logic [7:0] score_inc;
   logic       flap_edge;
   logic       pass;

   assign state     = st;
   assign flap_edge = flap & ~flap_q;
   // Only a downward crossing of PASS_X counts; a wrap from low to high x
   // has pipe_x_last low, so it can never qualify.
   assign pass      = (pipe_x_last >= PX) && (pipe_x < PX);

   // Saturating two-digit BCD increment of the current score.
   always_comb begin
      score_inc = score_bcd;
      if (score_bcd != 8'h99) begin
         if (score_bcd[3:0] == 4'd9)
            score_inc = {score_bcd[7:4] + 4'd1, 4'd0};
         else
            score_inc = {score_bcd[7:4], score_bcd[3:0] + 4'd1};
      end
   end

   // Round state machine with registered outputs and score bookkeeping.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         st          <= IDLE;
         motion_en   <= 1'b0;
         round_reset <= 1'b0;
         score_bcd   <= 8'h00;
         high_bcd    <= 8'h00;
         new_high    <= 1'b0;
         die_cnt     <= 8'd0;
         flap_q      <= 1'b0;
         pipe_x_last <= 10'd0;
      end else begin
         flap_q      <= flap;
         round_reset <= 1'b0;
         case (st)
            IDLE: begin
               // A tick coinciding with the start flap is deliberately unused.
               if (flap_edge) begin
                  st          <= PLAY;
                  motion_en   <= 1'b1;
                  score_bcd   <= 8'h00;
                  new_high    <= 1'b0;
                  pipe_x_last <= 10'd0;
               end
            end
            PLAY: begin
               if (frame_tick)
                  pipe_x_last <= pipe_x;
               if (collision) begin
                  // Collision wins over a same-cycle pass: compare the old score.
                  st        <= DYING;
                  motion_en <= 1'b0;
                  die_cnt   <= 8'd0;
                  if (score_bcd > high_bcd) begin
                     high_bcd <= score_bcd;
                     new_high <= 1'b1;
                  end
               end else if (frame_tick && pass) begin
                  score_bcd <= score_inc;
               end
            end
            DYING: begin
               if (frame_tick) begin
                  die_cnt <= die_cnt + 8'd1;
                  if (die_cnt == DIE_LAST)
                     st <= OVER;
               end
            end
            OVER: begin
               if (flap_edge) begin
                  st          <= IDLE;
                  round_reset <= 1'b1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: a behavioural model (integer score,
// converted to BCD) predicts the outputs for each driven cycle; predictions
// are queued and compared one cycle later against the DUT.
module tb_game_state_ctrl;

   localparam int DIE = 60;
   localparam int PX  = 265;

   logic       Clk = 1'b0;
   logic       Reset, frame_tick, flap, collision;
   logic [9:0] pipe_x;
   logic [1:0] state;
   logic       motion_en, round_reset, new_high;
   logic [7:0] score_bcd, high_bcd;

   game_state_ctrl #(.DIE_FRAMES(DIE), .PASS_X(PX)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .flap(flap),
      .collision(collision), .pipe_x(pipe_x), .state(state),
      .motion_en(motion_en), .round_reset(round_reset), .score_bcd(score_bcd),
      .high_bcd(high_bcd), .new_high(new_high)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [1:0] st;
      logic       me;
      logic       rr;
      logic [7:0] sc;
      logic [7:0] hi;
      logic       nh;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // model state
   int m_st = 0, m_score = 0, m_high = 0, m_die = 0, m_last = 0;
   bit m_me = 0, m_rr = 0, m_nh = 0, m_flq = 0;
   bit fl = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   // Drive one cycle, predict, then compare after the edge.
   task automatic cyc(input bit r, input bit t, input bit f, input bit c, input int px);
      exp_t e;
      bit   fe;
      Reset = r; frame_tick = t; flap = f; collision = c; pipe_x = 10'(px);
      if (r) begin
         m_st = 0; m_me = 0; m_rr = 0; m_score = 0; m_high = 0;
         m_nh = 0; m_die = 0; m_flq = 0; m_last = 0;
      end else begin
         fe    = f && !m_flq;
         m_flq = f;
         m_rr  = 0;
         case (m_st)
            0: if (fe) begin m_st = 1; m_me = 1; m_score = 0; m_nh = 0; m_last = 0; end
            1: begin
               if (c) begin
                  m_st = 2; m_me = 0; m_die = 0;
                  if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
               end else if (t && m_last >= PX && px < PX && m_score < 99) begin
                  m_score++;
               end
               if (t) m_last = px;
            end
            2: if (t) begin
               if (m_die == DIE - 1) m_st = 3;
               m_die++;
            end
            default: if (fe) begin m_st = 0; m_rr = 1; end
         endcase
      end
      e = '{st: 2'(m_st), me: m_me, rr: m_rr, sc: to_bcd(m_score),
            hi: to_bcd(m_high), nh: m_nh};
      sbq.push_back(e);
      @(posedge Clk);
      #1;
      e = sbq.pop_front();
      chk("state",       16'(state),       16'(e.st));
      chk("motion_en",   16'(motion_en),   16'(e.me));
      chk("round_reset", 16'(round_reset), 16'(e.rr));
      chk("score_bcd",   16'(score_bcd),   16'(e.sc));
      chk("high_bcd",    16'(high_bcd),    16'(e.hi));
      chk("new_high",    16'(new_high),    16'(e.nh));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, fl, 0, 500);
   endtask

   task automatic tick(input int px, input int gap);
      cyc(0, 1, fl, 0, px);
      for (int i = 0; i < gap; i++) cyc(0, 0, fl, 0, px);
   endtask

   task automatic pass1();
      tick(300, 1);
      tick(200, 0);
   endtask

   task automatic start_round();
      fl = 0; idle(1);
      fl = 1; idle(1);
      fl = 0;
   endtask

   task automatic collide();
      cyc(0, 0, fl, 1, 200);
   endtask

   // DYING with irregular tick spacing, flap edges and collisions ignored.
   task automatic die_out();
      for (int i = 0; i < DIE; i++) begin
         fl = (i % 4 == 1);
         cyc(0, 1, fl, (i % 5 == 0), 100);
         for (int g = 0; g < i % 3; g++) cyc(0, 0, fl, 1, 100);
      end
      fl = 0; idle(2);
   endtask

   task automatic leave_over();
      cyc(0, 0, 0, 1, 100);      // collision ignored in OVER
      fl = 1; idle(1);           // edge -> IDLE, round_reset pulse
      idle(2);                   // pulse lasts exactly one cycle
      fl = 0; idle(1);
   endtask

   initial begin
      // reset state
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 300);
      chk("reset_state", 16'(state), 16'd0);
      fl = 0; idle(2);
      cyc(0, 0, 0, 1, 0);        // collision ignored in IDLE

      // round 1: held flap gives one edge
      fl = 1; idle(1);
      chk("start_play", 16'(state), 16'd1);
      idle(3);
      fl = 0;
      tick(266, 0); tick(264, 1);           // score 1
      chk("first_pass", 16'(score_bcd), 16'h01);
      tick(3, 0); tick(400, 2);             // wrap: no score
      tick(264, 0);                         // 400 -> 264: score 2
      tick(266, 0); tick(265, 0);           // 265 is not below PASS_X
      tick(264, 0);                         // 265 -> 264: score 3
      collide();
      chk("high_r1", 16'(high_bcd), 16'h03);
      die_out();
      leave_over();

      // round 2: score 5 beats high 3
      start_round();
      for (int i = 0; i < 5; i++) pass1();
      collide();
      chk("high_r2", 16'(high_bcd), 16'h05);
      chk("new_high_r2", 16'(new_high), 16'd1);
      die_out();
      chk("over_r2", 16'(state), 16'd3);
      leave_over();

      // round 3: start flap with same-cycle passing tick, then collision+pass
      fl = 1;
      cyc(0, 1, 1, 0, 200);
      fl = 0;
      pass1(); pass1();
      tick(300, 0);
      cyc(0, 1, 0, 1, 200);                 // collision wins, score stays 2
      chk("col_pass_score", 16'(score_bcd), 16'h02);
      for (int i = 0; i < 30; i++) tick(100, i % 2);
      cyc(1, 0, 0, 0, 100);                 // reset mid-DYING
      chk("mid_reset_high", 16'(high_bcd), 16'h00);
      idle(1);

      // round 4: saturation, 0x09 -> 0x10 along the way
      start_round();
      for (int i = 0; i < 100; i++) begin
         pass1();
         if (i == 9) chk("bcd_carry", 16'(score_bcd), 16'h10);
      end
      chk("saturate", 16'(score_bcd), 16'h99);
      collide();
      die_out();
      leave_over();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Round-level controller that consumes the registered `collision` flag from the bird/pipe collision checker and sequences the game through IDLE, PLAY, DYING and OVER. It gates object motion, issues a one-cycle round reset to the bird and pipe movers, and keeps the BCD score and high score for the score display. It sits between the collision stage and the motion, sprite and score-display logic.

## Interface
Parameters:
- `DIE_FRAMES`, default 60: number of frame ticks spent in DYING. Legal range 1..255.
- `PASS_X`, default 265: pipe x coordinate whose downward crossing scores a point.

Ports:
- `Clk` input, 1 bit: system clock.
- `Reset` input, 1 bit: reset, synchronous, active-high.
- `frame_tick` input, 1 bit: one-Clk pulse per video frame.
- `flap` input, 1 bit: flap key level, already synchronous to Clk.
- `collision` input, 1 bit: registered collision flag from the collision checker.
- `pipe_x` input, 10 bits: current pipe x position. Pipes move leftward and wrap from low x to high x.
- `state` output, 2 bits: IDLE=0, PLAY=1, DYING=2, OVER=3.
- `motion_en` output, 1 bit: bird and pipe movers advance only while this is 1.
- `round_reset` output, 1 bit: one-cycle pulse that returns the bird and pipe to their start positions.
- `score_bcd` output, 8 bits: two BCD digits, tens in [7:4], units in [3:0].
- `high_bcd` output, 8 bits: best score since Reset, in BCD.
- `new_high` output, 1 bit: 1 when the last round set a new high score.

## Operation
- Flap edge: `flap_edge = flap & ~flap_q`, where `flap_q` is `flap` registered each Clk. A held key produces exactly one edge.
- IDLE:
  - `motion_en` = 0.
  - On `flap_edge`: go to PLAY, clear `score_bcd` to 0x00, clear `new_high`, clear `pipe_x_last` to 0.
- PLAY:
  - `motion_en` = 1.
  - `collision` = 1: go to DYING. This takes priority over scoring and `flap_edge`.
  - Otherwise, on `frame_tick`, a pass is `pipe_x_last >= PASS_X && pipe_x < PASS_X`. A pass increments `score_bcd` in BCD, saturating at 0x99.
  - `pipe_x_last` loads `pipe_x` on every `frame_tick` in PLAY.
  - A wrap from low x to high x never scores.
- Entry to DYING:
  - If `score_bcd > high_bcd` (plain 8-bit compare; BCD preserves ordering), load `high_bcd` with `score_bcd` and set `new_high`.
  - The death counter `die_cnt` (8 bits) clears to 0.
- DYING:
  - `motion_en` = 0.
  - `die_cnt` increments on each `frame_tick`.
  - On the tick where `die_cnt == DIE_FRAMES-1`: go to OVER.
  - `flap_edge` and `collision` are ignored.
- OVER:
  - `motion_en` = 0.
  - On `flap_edge`: go to IDLE and pulse `round_reset` for one cycle.
  - `score_bcd`, `high_bcd` and `new_high` hold their values.
- `collision` is ignored in IDLE, DYING and OVER.
- Reset values: `state` = IDLE, `motion_en` = 0, `round_reset` = 0, `score_bcd` = 0x00, `high_bcd` = 0x00, `new_high` = 0, `die_cnt` = 0, `flap_q` = 0, `pipe_x_last` = 0.
- `high_bcd` is cleared only by Reset, never by `round_reset`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- The state changes on the Clk edge after the cycle in which the triggering input is sampled.
- `motion_en` reflects the new state in that same edge, so it falls exactly one cycle after `collision` is first seen in PLAY.
- `round_reset` is high during the first cycle in IDLE after OVER, and only then.
- A score increment appears on `score_bcd` one cycle after the qualifying `frame_tick`.
- Simultaneous events:
  - `collision` and a passing `frame_tick` in the same cycle: go to DYING, no increment. The high-score compare uses the old score.
  - `flap_edge` and `frame_tick` in IDLE: go to PLAY. The tick is not used for scoring.
- Reset asserted in any state, including mid-DYING: all registers take their reset values on the next edge.
- Duration of DYING: exactly `DIE_FRAMES` `frame_tick` pulses, independent of the tick spacing.

## Test plan
- Reset, then `flap` rising: `state` 0→1 next cycle, `motion_en`=1, `score_bcd`=0x00. Holding `flap` high gives no further edges.
- In PLAY, `pipe_x` sampled at 266 then 264 on successive ticks: `score_bcd` 0x00→0x01. A wrap 3→400 leaves the score unchanged. 100 passes saturate at 0x99; a pass from 0x09 gives 0x10.
- PLAY with score 0x05 and `high_bcd` 0x03, pulse `collision`: next cycle `state`=2, `motion_en`=0, `high_bcd`=0x05, `new_high`=1. After 60 ticks `state`=3.
- In OVER, `flap` edge: `state`=0 and `round_reset`=1 for exactly one cycle. A second edge gives PLAY with `score_bcd`=0x00 and `high_bcd` still 0x05.
- Collision and a passing tick in the same cycle at score 0x02: `state`=2, `score_bcd` stays 0x02.
- Reset asserted at DYING tick 30: next cycle all outputs are at reset values and `high_bcd`=0x00.
